jk_cmd_sequencer: RTL and testbench
===================================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO depth (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning width of the repeat field.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: command accepted on this edge if cmd_valid is high.
REQ-007 The block SHALL have port cmd_op, input, 2 bits: 0 HOLD, 1 CLEAR, 2 SET, 3 TOGGLE.
REQ-008 The block SHALL have port cmd_rpt, input, CNT_W bits: issue count minus one.
REQ-009 The block SHALL have ports j and k, outputs, 1 bit each: registered drive to the downstream JK flip-flop.
REQ-010 The block SHALL have ports q_fb and qb_fb, inputs, 1 bit each: Q and Qb fed back from the flop.
REQ-011 The block SHALL have port exp_q, output, 1 bit: modelled flop state; exp_vld, output, 1 bit: model known.
REQ-012 The block SHALL have ports err_mismatch and err_compl, outputs, 1 bit each: sticky error flags; err_clr, input, 1 bit: clears both flags.
REQ-013 The block SHALL have port busy, output, 1 bit: FIFO non-empty or state DRIVE.

Function
REQ-014 Handshake: cmd_ready = !full; a push occurs on an edge with cmd_valid && cmd_ready; a push is never accepted when full, even if a pop occurs on the same edge.
REQ-015 Op encoding on j/k: HOLD 0/0, CLEAR 0/1, SET 1/0, TOGGLE 1/1.
REQ-016 FSM states are IDLE and DRIVE; in IDLE, j=k=0.
REQ-017 IDLE->DRIVE on an edge with FIFO non-empty: pop head, load j/k from op, rem <= rpt.
REQ-018 In DRIVE, each edge with rem>0 decrements rem and holds j/k.
REQ-019 In DRIVE, an edge with rem==0 pops and loads the next command if the FIFO is non-empty (no bubble); otherwise the FSM goes to IDLE with j=k=0.
REQ-020 Latency: a command accepted at edge N drives j/k from edge N+1, for exactly rpt+1 cycles, when the FIFO was empty and the FSM was idle.
REQ-021 The model SHALL update at every edge from the current j/k: 0/0 keep, 0/1 clear to 0, 1/0 set to 1, 1/1 invert.
REQ-022 exp_vld SHALL be set on the edge where j/k is SET or CLEAR, and SHALL be unchanged otherwise.
REQ-023 The checker SHALL sample on every edge while exp_vld=1: set err_mismatch if q_fb != exp_q, and set err_compl if q_fb == qb_fb.
REQ-024 Error flags remain set until err_clr; when a detection and err_clr coincide, the set wins.
REQ-025 Boundaries: the FIFO pointers wrap modulo DEPTH; a push into an empty FIFO while IDLE pops on the following edge; rpt = all-ones gives 2^CNT_W issues.

Reset
REQ-026 While rst is high: FIFO empty, cmd_ready=0, state IDLE, j=k=0, rem=0, exp_q=0, exp_vld=0, err_*=0, busy=0.
REQ-027 Reset asserted mid-command SHALL abort it immediately and discard all queued commands; cmd_ready rises on the first edge after rst deasserts.

Structure
REQ-028 Shared package jk_pkg SHALL hold the op encodings (OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE) and the FSM state type.
REQ-029 The FIFO SHALL be a sub-module jk_cmd_fifo (synchronous, single clock, async reset, width 2+CNT_W, DEPTH entries, full/empty flags).

Verification
REQ-030 The bench SHALL cover: reset, push SET rpt=0 at edge N -> j/k=1/0 during cycle N+1 only; exp_q=1 and exp_vld=1 after edge N+2.
REQ-031 The bench SHALL cover: push TOGGLE rpt=3 after SET -> j=k=1 for 4 cycles; exp_q sequence 0,1,0,1; no errors with an ideal flop model.
REQ-032 The bench SHALL cover: hold cmd_valid with 5 commands, DEPTH=4, FSM busy -> cmd_ready=0 after 4 pushes; back-to-back commands with no HOLD gap between them.
REQ-033 The bench SHALL cover: force q_fb inverted after SET -> err_mismatch=1 on the next edge; it stays set until err_clr; err_clr coincident with a new mismatch leaves it set.
REQ-034 The bench SHALL cover: tie qb_fb=q_fb with exp_vld=1 -> err_compl=1; with exp_vld=0 (before any SET/CLEAR) -> no error.
REQ-035 The bench SHALL cover: assert rst during a rpt=7 command with 2 queued -> j=k=0 immediately; busy=0; the queued commands are never issued after release.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK command sequencer.
//   op_e     - command opcode, encoded so that the value equals {j,k}
//   state_e  - sequencer FSM state
//   op_to_jk - opcode to {j,k} drive pair
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_CLEAR  = 2'd1,
    OP_SET    = 2'd2,
    OP_TOGGLE = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  localparam int OP_W = 2;

  function automatic logic [1:0] op_to_jk(input op_e op);
    logic [1:0] jk;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_CLEAR:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: single-clock synchronous FIFO holding queued commands.
//   clk, rst    - clock, asynchronous active-high reset
//   i_wr_en     - push i_wr_data (ignored when full)
//   i_rd_en     - pop head (ignored when empty)
//   o_rd_data   - head entry, valid while !o_empty
//   o_full      - DEPTH entries held
//   o_empty     - no entries held
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == C_FULL);
  assign o_empty   = (r_count == '0);
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues {op, repeat} commands and drives a downstream JK
// flop, tracking the expected flop state and checking the fed-back Q/Qb.
//   clk, rst              - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake
//   cmd_op, cmd_rpt       - opcode and issue count minus one
//   j, k                  - registered drive to the flop
//   q_fb, qb_fb           - flop outputs fed back
//   exp_q, exp_vld        - modelled flop state and whether it is known
//   err_mismatch          - sticky: q_fb differed from exp_q
//   err_compl             - sticky: q_fb equalled qb_fb
//   err_clr               - clears both sticky flags
//   busy                  - commands queued or being driven
//
// state    | meaning
// ST_IDLE  | nothing being issued, j=k=0
// ST_DRIVE | j/k held from current command, r_rem more issues after this one
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_rpt,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  input  logic             qb_fb,
  output logic             exp_q,
  output logic             exp_vld,
  output logic             err_mismatch,
  output logic             err_compl,
  input  logic             err_clr,
  output logic             busy
);

  localparam int FW = OP_W + CNT_W;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [FW-1:0]    w_wr_data;
  logic [FW-1:0]    w_head;
  op_e              w_head_op;
  logic [CNT_W-1:0] w_head_rpt;
  logic [1:0]       w_head_jk;

  logic             r_rdy_en;
  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_j;
  logic             r_k;
  logic             w_j_nxt;
  logic             w_k_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;

  logic             r_exp_q;
  logic             r_exp_vld;
  logic             r_err_mm;
  logic             r_err_cp;
  logic             w_det_mm;
  logic             w_det_cp;

  // r_rdy_en keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready  = r_rdy_en && !w_full;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_wr_data  = {cmd_op, cmd_rpt};
  assign w_head_op  = op_e'(w_head[FW-1 -: OP_W]);
  assign w_head_rpt = w_head[CNT_W-1:0];
  assign w_head_jk  = op_to_jk(w_head_op);

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_en <= 1'b0;
      r_state  <= ST_IDLE;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_rem    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_state  <= w_state_nxt;
      r_j      <= w_j_nxt;
      r_k      <= w_k_nxt;
      r_rem    <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_rem_nxt   = r_rem;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_j_nxt = 1'b0;
        w_k_nxt = 1'b0;
        if (!w_empty) begin
          w_pop                = 1'b1;
          w_state_nxt          = ST_DRIVE;
          {w_j_nxt, w_k_nxt}   = w_head_jk;
          w_rem_nxt            = w_head_rpt;
        end
      end
      ST_DRIVE: begin
        if (r_rem != '0) begin
          w_rem_nxt = r_rem - 1'b1;
        end else if (!w_empty) begin
          // Chain straight into the next command so there is no idle bubble.
          w_pop                = 1'b1;
          {w_j_nxt, w_k_nxt}   = w_head_jk;
          w_rem_nxt            = w_head_rpt;
        end else begin
          w_state_nxt = ST_IDLE;
          w_j_nxt     = 1'b0;
          w_k_nxt     = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
      end
    endcase
  end

  // Checker compares against the model value held before this edge.
  assign w_det_mm = r_exp_vld && (q_fb != r_exp_q);
  assign w_det_cp = r_exp_vld && (q_fb == qb_fb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_q   <= 1'b0;
      r_exp_vld <= 1'b0;
      r_err_mm  <= 1'b0;
      r_err_cp  <= 1'b0;
    end else begin
      case ({r_j, r_k})
        2'b01:   r_exp_q <= 1'b0;
        2'b10:   r_exp_q <= 1'b1;
        2'b11:   r_exp_q <= ~r_exp_q;
        default: r_exp_q <= r_exp_q;
      endcase
      // Only SET or CLEAR leave the flop in a known state.
      if (r_j ^ r_k) r_exp_vld <= 1'b1;

      // A new detection takes priority over a coincident clear.
      if (w_det_mm)     r_err_mm <= 1'b1;
      else if (err_clr) r_err_mm <= 1'b0;
      if (w_det_cp)     r_err_cp <= 1'b1;
      else if (err_clr) r_err_cp <= 1'b0;
    end
  end

  assign j            = r_j;
  assign k            = r_k;
  assign exp_q        = r_exp_q;
  assign exp_vld      = r_exp_vld;
  assign err_mismatch = r_err_mm;
  assign err_compl    = r_err_cp;
  assign busy         = !w_empty || (r_state == ST_DRIVE);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;
  import jk_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_rpt;
  logic             j;
  logic             k;
  logic             q_fb;
  logic             qb_fb;
  logic             exp_q;
  logic             exp_vld;
  logic             err_mismatch;
  logic             err_compl;
  logic             err_clr;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rpt      (cmd_rpt),
    .j            (j),
    .k            (k),
    .q_fb         (q_fb),
    .qb_fb        (qb_fb),
    .exp_q        (exp_q),
    .exp_vld      (exp_vld),
    .err_mismatch (err_mismatch),
    .err_compl    (err_compl),
    .err_clr      (err_clr),
    .busy         (busy)
  );

  // Ideal downstream JK flop, with fault injection on its feedback.
  logic fq;
  bit   fb_inv;
  bit   fb_tie;
  always @(posedge clk or posedge rst) begin
    if (rst) fq <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   fq <= 1'b0;
        2'b10:   fq <= 1'b1;
        2'b11:   fq <= ~fq;
        default: fq <= fq;
      endcase
    end
  end
  assign q_fb  = fb_inv ? ~fq : fq;
  assign qb_fb = fb_tie ? q_fb : ~q_fb;

  // Reference model: every accepted command expands into rpt+1 per-cycle
  // {first, j, k} slots; one slot is issued per edge. Queued command count is
  // the number of slots still marked as a command's first issue.
  bit [2:0] mq[$];
  bit       m_j, m_k, m_rdy_en, m_drv, m_q, m_vld, m_emm, m_ecp;
  bit       mdl_push;
  bit [2:0] mdl_e;

  function automatic int occ();
    int n = 0;
    foreach (mq[i]) if (mq[i][2]) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return m_rdy_en && (occ() < DEPTH);
  endfunction

  function automatic logic [7:0] m_vec();
    return {m_ready(), m_j, m_k, (occ() > 0) || m_drv, m_q, m_vld, m_emm, m_ecp};
  endfunction

  wire [7:0] dut_vec = {cmd_ready, j, k, busy, exp_q, exp_vld, err_mismatch, err_compl};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_j = 0; m_k = 0; m_rdy_en = 0; m_drv = 0;
      m_q = 0; m_vld = 0; m_emm = 0; m_ecp = 0;
    end else begin
      mdl_push = cmd_valid && m_ready();
      if (m_vld && (q_fb != m_q)) m_emm = 1'b1;
      else if (err_clr)           m_emm = 1'b0;
      if (m_vld && (q_fb == qb_fb)) m_ecp = 1'b1;
      else if (err_clr)             m_ecp = 1'b0;
      if (m_j && !m_k)      m_q = 1'b1;
      else if (!m_j && m_k) m_q = 1'b0;
      else if (m_j && m_k)  m_q = !m_q;
      if (m_j != m_k) m_vld = 1'b1;
      if (mq.size() > 0) begin
        mdl_e = mq.pop_front();
        m_j = mdl_e[1]; m_k = mdl_e[0]; m_drv = 1'b1;
      end else begin
        m_j = 1'b0; m_k = 1'b0; m_drv = 1'b0;
      end
      if (mdl_push)
        for (int i = 0; i <= int'(cmd_rpt); i++) mq.push_back({i == 0, cmd_op});
      m_rdy_en = 1'b1;
    end
  end

  task automatic do_reset();
    cmd_valid = 0; err_clr = 0; fb_inv = 0; fb_tie = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic push_one(input logic [1:0] op, input logic [CNT_W-1:0] rpt);
    cmd_op = op; cmd_rpt = rpt; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut_vec !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b want 00000000", dut_vec); end
    rst = 0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", cmd_ready); end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b want 1", cmd_ready); end
    n_cmp++;
    if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL model_after_reset: got %b want %b", dut_vec, m_vec()); end
  endtask

  task automatic test_set_latency();
    do_reset();
    push_one(OP_SET, 4'd0);
    n_cmp++;
    if ({j, k, busy} !== 3'b001) begin n_fail++; $display("FAIL set_cycle_n: jk,busy=%b want 001", {j, k, busy}); end
    @(negedge clk);
    n_cmp++;
    if ({j, k, exp_vld} !== 3'b100) begin n_fail++; $display("FAIL set_cycle_n1: jk,vld=%b want 100", {j, k, exp_vld}); end
    @(negedge clk);
    n_cmp++;
    if ({j, k, exp_q, exp_vld} !== 4'b0011) begin n_fail++; $display("FAIL set_cycle_n2: jk,q,vld=%b want 0011", {j, k, exp_q, exp_vld}); end
    n_cmp++;
    if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL set_model: got %b want %b", dut_vec, m_vec()); end
  endtask

  task automatic test_toggle();
    push_one(OP_TOGGLE, 4'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({j, k} !== ((c < 4) ? 2'b11 : 2'b00) || exp_q !== ((c % 2) == 0) ||
          {err_mismatch, err_compl} !== 2'b00) begin
        n_fail++;
        $display("FAIL toggle_c%0d: jk=%b q=%b errs=%b want jk=%b q=%0d errs=00",
                 c, {j, k}, exp_q, {err_mismatch, err_compl}, (c < 4) ? 2'b11 : 2'b00, (c % 2) == 0);
      end
    end
  endtask

  task automatic test_rpt_max();
    int n_tog = 0;
    do_reset();
    push_one(OP_TOGGLE, 4'hF);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (j && k) n_tog++;
      n_cmp++;
      if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL rpt_max_c%0d: got %b want %b", c, dut_vec, m_vec()); end
    end
    n_cmp++;
    if (n_tog != 16) begin n_fail++; $display("FAIL rpt_max_count: got %0d want 16", n_tog); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]       ops  [5] = '{OP_SET, OP_CLEAR, OP_TOGGLE, OP_SET, OP_CLEAR};
    logic [CNT_W-1:0] rpts [5] = '{4'd1, 4'd0, 4'd2, 4'd0, 4'd1};
    int  idx = 0, first = -1, last = -1, cyc = 0;
    bit  acc, full_seen = 0;
    do_reset();
    push_one(OP_HOLD, 4'd6);
    while ((idx < 5 || busy) && cyc < 60) begin
      if (idx < 5) begin cmd_op = ops[idx]; cmd_rpt = rpts[idx]; cmd_valid = 1; end
      else cmd_valid = 0;
      acc = (idx < 5) && m_ready();
      @(negedge clk);
      if (acc) idx++;
      if ({j, k} != 2'b00) begin if (first < 0) first = cyc; last = cyc; end
      n_cmp++;
      if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL b2b_c%0d: got %b want %b", cyc, dut_vec, m_vec()); end
      if (idx == 4 && !full_seen) begin
        full_seen = 1;
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL b2b_full: ready,busy=%b want 01", {cmd_ready, busy}); end
      end
      cyc++;
    end
    cmd_valid = 0;
    n_cmp++;
    if (idx < 5 || busy) begin n_fail++; $display("FAIL b2b_timeout: idx=%0d busy=%b want 5/0", idx, busy); end
    n_cmp++;
    if (last - first + 1 != 9) begin n_fail++; $display("FAIL b2b_span: got %0d want 9", last - first + 1); end
  endtask

  task automatic test_mismatch();
    do_reset();
    push_one(OP_SET, 4'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({exp_vld, err_mismatch} !== 2'b10) begin n_fail++; $display("FAIL mm_pre: vld,mm=%b want 10", {exp_vld, err_mismatch}); end
    fb_inv = 1;
    @(negedge clk);
    n_cmp++;
    if ({err_mismatch, err_compl} !== 2'b10) begin n_fail++; $display("FAIL mm_set: mm,cp=%b want 10", {err_mismatch, err_compl}); end
    fb_inv = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_sticky: got %b want 1", err_mismatch); end
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    n_cmp++;
    if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL mm_cleared: got %b want 0", err_mismatch); end
    fb_inv = 1; err_clr = 1;
    @(negedge clk);
    n_cmp++;
    if (err_mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_set_wins: got %b want 1", err_mismatch); end
    fb_inv = 0;
    @(negedge clk);
    err_clr = 0;
    n_cmp++;
    if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL mm_model: got %b want %b", dut_vec, m_vec()); end
  endtask

  task automatic test_compl();
    do_reset();
    fb_tie = 1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({exp_vld, err_compl, err_mismatch} !== 3'b000) begin n_fail++; $display("FAIL compl_no_vld: vld,cp,mm=%b want 000", {exp_vld, err_compl, err_mismatch}); end
    push_one(OP_CLEAR, 4'd0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({exp_vld, err_compl, err_mismatch} !== 3'b110) begin n_fail++; $display("FAIL compl_set: vld,cp,mm=%b want 110", {exp_vld, err_compl, err_mismatch}); end
    fb_tie = 0;
  endtask

  task automatic test_reset_abort();
    do_reset();
    cmd_op = OP_TOGGLE; cmd_rpt = 4'd7; cmd_valid = 1;
    @(negedge clk);
    cmd_op = OP_SET; cmd_rpt = 4'd0;
    @(negedge clk);
    cmd_op = OP_CLEAR; cmd_rpt = 4'd0;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({j, k, busy} !== 3'b111) begin n_fail++; $display("FAIL abort_pre: jk,busy=%b want 111", {j, k, busy}); end
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({j, k, busy, cmd_ready} !== 4'b0000) begin n_fail++; $display("FAIL abort_immediate: jk,busy,rdy=%b want 0000", {j, k, busy, cmd_ready}); end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({j, k, busy, exp_vld} !== 4'b0000 || dut_vec !== m_vec()) begin
        n_fail++;
        $display("FAIL abort_after_c%0d: jk,busy,vld=%b want 0000 vec=%b model=%b", c, {j, k, busy, exp_vld}, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_rpt   = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 15) == 0);
      fb_inv    = ($urandom_range(0, 31) == 0);
      fb_tie    = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec()) begin n_fail++; $display("FAIL random_c%0d: got %b want %b", c, dut_vec, m_vec()); end
    end
    cmd_valid = 0; err_clr = 0; fb_inv = 0; fb_tie = 0;
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = 2'b00; cmd_rpt = '0; err_clr = 0;
    fb_inv = 0; fb_tie = 0;
    test_reset();
    test_set_latency();
    test_toggle();
    test_rpt_max();
    test_back_to_back();
    test_mismatch();
    test_compl();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
